// File: rtl/datamover_mc_ctrl_pkg.sv
// Shared types for the multi-channel datamover control core: FSM states,
// job descriptor, addressgen field layout and the helper that packs it.
package datamover_mc_package;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_STARTING,
        MC_WORKING,
        MC_FINISHED
    } mc_state_e;

    // One addressgen setup; a channel config carries one for source and one for sink.
    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] tot_len;
        logic [31:0] d0_len;
        logic [31:0] d0_stride;
        logic [31:0] d1_len;
        logic [31:0] d1_stride;
        logic [15:0] mode;
    } addrgen_cfg_t;

    localparam int AG_W          = $bits(addrgen_cfg_t);
    localparam int CFG_W_DEFAULT = 2 * AG_W;
    localparam int CH_W_DEFAULT  = 1;

    typedef struct packed {
        logic [CH_W_DEFAULT-1:0]  chan;
        logic [CFG_W_DEFAULT-1:0] cfg;
    } mc_job_t;

    // Sink fields occupy the upper half, source fields the lower half.
    function automatic logic [CFG_W_DEFAULT-1:0] pack_cfg(input addrgen_cfg_t src,
                                                          input addrgen_cfg_t snk);
        return {snk, src};
    endfunction

endpackage

// File: rtl/datamover_mc_ctrl_chan_fsm.sv
// One channel's start/work/finish sequencer with its config latch,
// saturating busy-cycle counter and sticky abort flag.
module datamover_mc_chan_fsm
    import datamover_mc_package::*;
#(
    parameter int CFG_W = CFG_W_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CFG_W-1:0] cfg_i,
    input  logic             abort_i,
    input  logic             src_done_i,
    input  logic             src_ready_start_i,
    input  logic             snk_done_i,
    input  logic             snk_ready_start_i,
    input  logic             fifo_empty_i,
    output logic [CFG_W-1:0] cfg_o,
    output logic             req_start_o,
    output logic             busy_o,
    output logic             done_evt_o,
    output logic             aborted_o,
    output logic [CNT_W-1:0] cycles_o
);

    mc_state_e        state_q, state_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             xfer_end;

    assign xfer_end = (src_done_i | src_ready_start_i) & (snk_done_i | snk_ready_start_i)
                    & fifo_empty_i;

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        aborted_d = aborted_q;
        cycles_d  = cycles_q;
        if ((state_q == MC_STARTING || state_q == MC_WORKING) && cycles_q != '1)
            cycles_d = cycles_q + CNT_W'(1);
        unique case (state_q)
            MC_IDLE: begin
                if (start_i) begin
                    state_d   = MC_STARTING;
                    cfg_d     = cfg_i;
                    aborted_d = 1'b0;
                    cycles_d  = '0;
                end
            end
            MC_STARTING: begin
                state_d = MC_WORKING;
                if (abort_i) begin
                    state_d   = MC_FINISHED;
                    aborted_d = 1'b1;
                end
            end
            MC_WORKING: begin
                if (abort_i) begin
                    state_d   = MC_FINISHED;
                    aborted_d = 1'b1;
                end else if (xfer_end) begin
                    state_d = MC_FINISHED;
                end
            end
            MC_FINISHED: state_d = MC_IDLE;
            default:     state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= MC_IDLE;
            cfg_q     <= '0;
            aborted_q <= 1'b0;
            cycles_q  <= '0;
        end else if (clear_i) begin
            state_q   <= MC_IDLE;
            cfg_q     <= '0;
            aborted_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            aborted_q <= aborted_d;
            cycles_q  <= cycles_d;
        end
    end

    assign cfg_o       = cfg_q;
    assign req_start_o = (state_q == MC_STARTING);
    assign busy_o      = (state_q != MC_IDLE);
    assign done_evt_o  = (state_q == MC_FINISHED);
    assign aborted_o   = aborted_q;
    assign cycles_o    = cycles_q;

endmodule

// File: rtl/datamover_mc_ctrl.sv
// Multi-channel datamover control: in-order shared job queue feeding one
// start/work/finish sequencer per source/sink streamer pair.
module datamover_mc_ctrl
    import datamover_mc_package::*;
#(
    parameter int N_CHANNELS = 2,
    parameter int JOB_DEPTH  = 4,
    parameter int CFG_W      = CFG_W_DEFAULT,
    parameter int CNT_W      = 32,
    parameter int CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  job_valid_i,
    output logic                                  job_ready_o,
    input  logic [CH_W-1:0]                       job_chan_i,
    input  logic [CFG_W-1:0]                      job_cfg_i,
    input  logic [N_CHANNELS-1:0]                 abort_i,
    output logic [N_CHANNELS-1:0][CFG_W-1:0]      cfg_o,
    output logic [N_CHANNELS-1:0]                 src_req_start_o,
    output logic [N_CHANNELS-1:0]                 snk_req_start_o,
    input  logic [N_CHANNELS-1:0]                 src_done_i,
    input  logic [N_CHANNELS-1:0]                 src_ready_start_i,
    input  logic [N_CHANNELS-1:0]                 snk_done_i,
    input  logic [N_CHANNELS-1:0]                 snk_ready_start_i,
    input  logic [N_CHANNELS-1:0]                 fifo_empty_i,
    output logic [N_CHANNELS-1:0]                 busy_o,
    output logic [N_CHANNELS-1:0]                 done_evt_o,
    output logic [N_CHANNELS-1:0]                 aborted_o,
    output logic [N_CHANNELS-1:0][CNT_W-1:0]      cycles_o,
    output logic [$clog2(JOB_DEPTH+1)-1:0]        queue_cnt_o
);

    localparam int PTR_W = $clog2(JOB_DEPTH);
    localparam int QC_W  = $clog2(JOB_DEPTH+1);

    typedef struct packed {
        logic [CH_W-1:0]  chan;
        logic [CFG_W-1:0] cfg;
    } job_t;

    job_t                  mem_q [JOB_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QC_W-1:0]       cnt_q, cnt_d;
    logic                  ready_q;
    logic                  push, pop, drop, head_vld;
    logic [N_CHANNELS-1:0] start, busy, req_start;
    job_t                  head;

    assign head     = mem_q[rd_ptr_q];
    assign head_vld = (cnt_q != '0);
    assign push     = job_valid_i & ready_q;
    // Out-of-range targets are retired from the head without touching any channel.
    assign drop     = head_vld && (int'(head.chan) >= N_CHANNELS);

    always_comb begin
        start = '0;
        for (int c = 0; c < N_CHANNELS; c++)
            if (head_vld && int'(head.chan) == c && !busy[c]) start[c] = 1'b1;
    end

    assign pop      = (|start) | drop;
    assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign cnt_d    = cnt_q + QC_W'(push) - QC_W'(pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= (int'(cnt_d) < JOB_DEPTH);
        end
    end

    // Payload storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) mem_q[wr_ptr_q] <= '{chan: job_chan_i, cfg: job_cfg_i};
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        datamover_mc_chan_fsm #(
            .CFG_W (CFG_W),
            .CNT_W (CNT_W)
        ) u_fsm (
            .clk_i             (clk_i),
            .rst_ni            (rst_ni),
            .clear_i           (clear_i),
            .start_i           (start[c]),
            .cfg_i             (head.cfg),
            .abort_i           (abort_i[c]),
            .src_done_i        (src_done_i[c]),
            .src_ready_start_i (src_ready_start_i[c]),
            .snk_done_i        (snk_done_i[c]),
            .snk_ready_start_i (snk_ready_start_i[c]),
            .fifo_empty_i      (fifo_empty_i[c]),
            .cfg_o             (cfg_o[c]),
            .req_start_o       (req_start[c]),
            .busy_o            (busy[c]),
            .done_evt_o        (done_evt_o[c]),
            .aborted_o         (aborted_o[c]),
            .cycles_o          (cycles_o[c])
        );
    end

    assign src_req_start_o = req_start;
    assign snk_req_start_o = req_start;
    assign busy_o          = busy;
    assign job_ready_o     = ready_q;
    assign queue_cnt_o     = cnt_q;

endmodule

// File: tb/tb_datamover_mc_ctrl.sv
// Directed bench for datamover_mc_ctrl; a second CNT_W=4 instance shares
// the stimulus so counter saturation can be observed.
module tb_datamover_mc_ctrl;
    import datamover_mc_package::*;

    localparam int CW = CFG_W_DEFAULT;

    logic clk_i = 1'b0;
    logic rst_ni, clear_i, job_valid_i;
    logic [0:0] job_chan_i;
    logic [CW-1:0] job_cfg_i;
    logic [1:0] abort_i, src_done_i, src_ready_start_i, snk_done_i, snk_ready_start_i, fifo_empty_i;

    logic job_ready_o;
    logic [1:0][CW-1:0] cfg_o;
    logic [1:0] src_req_start_o, snk_req_start_o, busy_o, done_evt_o, aborted_o;
    logic [1:0][31:0] cycles_o;
    logic [2:0] queue_cnt_o;

    logic s_job_ready_o;
    logic [1:0][CW-1:0] s_cfg_o;
    logic [1:0] s_src_req_start_o, s_snk_req_start_o, s_busy_o, s_done_evt_o, s_aborted_o;
    logic [1:0][3:0] s_cycles_o;
    logic [2:0] s_queue_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    datamover_mc_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .job_valid_i(job_valid_i),
        .job_ready_o(job_ready_o), .job_chan_i(job_chan_i), .job_cfg_i(job_cfg_i),
        .abort_i(abort_i), .cfg_o(cfg_o), .src_req_start_o(src_req_start_o),
        .snk_req_start_o(snk_req_start_o), .src_done_i(src_done_i),
        .src_ready_start_i(src_ready_start_i), .snk_done_i(snk_done_i),
        .snk_ready_start_i(snk_ready_start_i), .fifo_empty_i(fifo_empty_i),
        .busy_o(busy_o), .done_evt_o(done_evt_o), .aborted_o(aborted_o),
        .cycles_o(cycles_o), .queue_cnt_o(queue_cnt_o)
    );

    datamover_mc_ctrl #(.CNT_W(4)) dut_s (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .job_valid_i(job_valid_i),
        .job_ready_o(s_job_ready_o), .job_chan_i(job_chan_i), .job_cfg_i(job_cfg_i),
        .abort_i(abort_i), .cfg_o(s_cfg_o), .src_req_start_o(s_src_req_start_o),
        .snk_req_start_o(s_snk_req_start_o), .src_done_i(src_done_i),
        .src_ready_start_i(src_ready_start_i), .snk_done_i(snk_done_i),
        .snk_ready_start_i(snk_ready_start_i), .fifo_empty_i(fifo_empty_i),
        .busy_o(s_busy_o), .done_evt_o(s_done_evt_o), .aborted_o(s_aborted_o),
        .cycles_o(s_cycles_o), .queue_cnt_o(s_queue_cnt_o)
    );

    function automatic logic [CW-1:0] mk_cfg(input logic [31:0] b);
        addrgen_cfg_t s, k;
        s = '{base_addr: b, tot_len: 32'd64, d0_len: 32'd8, d0_stride: 32'd4,
              d1_len: 32'd8, d1_stride: 32'd32, mode: 16'h0001};
        k = s;
        k.base_addr = b ^ 32'hFFFF_0000;
        return pack_cfg(s, k);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [0:0] ch, input logic [CW-1:0] c);
        job_valid_i = 1'b1;
        job_chan_i  = ch;
        job_cfg_i   = c;
        tick();
        job_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; job_valid_i = 1'b0; job_chan_i = '0; job_cfg_i = '0;
        abort_i = '0; src_done_i = '0; src_ready_start_i = '0; snk_done_i = '0;
        snk_ready_start_i = '0; fifo_empty_i = 2'b11;
        #12;
        checks++; if (job_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", job_ready_o); end
        checks++; if (busy_o !== 2'b00 || done_evt_o !== 2'b00 || src_req_start_o !== 2'b00) begin errors++; $display("FAIL rst_outs busy %b done %b req %b exp 0", busy_o, done_evt_o, src_req_start_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        checks++; if (job_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_rel got %b exp 1", job_ready_o); end
        checks++; if (queue_cnt_o !== 3'd0 || cycles_o !== '0 || aborted_o !== 2'b00) begin errors++; $display("FAIL rst_state cnt %0d cyc %h ab %b exp 0", queue_cnt_o, cycles_o, aborted_o); end
    endtask

    task automatic test_single();
        push(1'b0, mk_cfg(32'h1000));
        checks++; if (queue_cnt_o !== 3'd1 || busy_o !== 2'b00) begin errors++; $display("FAIL s_push cnt %0d busy %b exp 1 00", queue_cnt_o, busy_o); end
        tick();
        checks++; if (src_req_start_o !== 2'b01 || snk_req_start_o !== 2'b01) begin errors++; $display("FAIL s_req src %b snk %b exp 01", src_req_start_o, snk_req_start_o); end
        checks++; if (cfg_o[0] !== mk_cfg(32'h1000)) begin errors++; $display("FAIL s_cfg got %h exp %h", cfg_o[0], mk_cfg(32'h1000)); end
        checks++; if (busy_o !== 2'b01 || queue_cnt_o !== 3'd0) begin errors++; $display("FAIL s_busy busy %b cnt %0d exp 01 0", busy_o, queue_cnt_o); end
        tick();
        checks++; if (src_req_start_o !== 2'b00 || cycles_o[0] !== 32'd1) begin errors++; $display("FAIL s_w1 req %b cyc %0d exp 00 1", src_req_start_o, cycles_o[0]); end
        tick(); tick(); tick();
        src_done_i[0] = 1'b1; snk_ready_start_i[0] = 1'b1; fifo_empty_i[0] = 1'b0;
        tick();
        checks++; if (busy_o !== 2'b01 || done_evt_o !== 2'b00 || cycles_o[0] !== 32'd5) begin errors++; $display("FAIL s_fifo busy %b done %b cyc %0d exp 01 00 5", busy_o, done_evt_o, cycles_o[0]); end
        fifo_empty_i[0] = 1'b1;
        tick();
        checks++; if (done_evt_o !== 2'b01 || cycles_o[0] !== 32'd6) begin errors++; $display("FAIL s_done done %b cyc %0d exp 01 6", done_evt_o, cycles_o[0]); end
        src_done_i = '0; snk_ready_start_i = '0;
        tick();
        checks++; if (done_evt_o !== 2'b00 || busy_o !== 2'b00 || cycles_o[0] !== 32'd6) begin errors++; $display("FAIL s_idle done %b busy %b cyc %0d exp 00 00 6", done_evt_o, busy_o, cycles_o[0]); end
    endtask

    task automatic test_queue_order();
        push(1'b0, mk_cfg(32'h2000));
        push(1'b0, mk_cfg(32'h2100));
        push(1'b0, mk_cfg(32'h2200));
        push(1'b1, mk_cfg(32'h2300));
        push(1'b1, mk_cfg(32'h2400));
        checks++; if (job_ready_o !== 1'b0 || queue_cnt_o !== 3'd4) begin errors++; $display("FAIL q_full ready %b cnt %0d exp 0 4", job_ready_o, queue_cnt_o); end
        push(1'b1, mk_cfg(32'h2500));
        checks++; if (queue_cnt_o !== 3'd4 || busy_o !== 2'b01) begin errors++; $display("FAIL q_nopush cnt %0d busy %b exp 4 01", queue_cnt_o, busy_o); end
        src_done_i[0] = 1'b1; snk_done_i[0] = 1'b1;
        tick();
        checks++; if (done_evt_o !== 2'b01) begin errors++; $display("FAIL q_done0 got %b exp 01", done_evt_o); end
        src_done_i = '0; snk_done_i = '0;
        tick(); tick();
        checks++; if (job_ready_o !== 1'b1 || queue_cnt_o !== 3'd3 || cfg_o[0] !== mk_cfg(32'h2100)) begin errors++; $display("FAIL q_j1 ready %b cnt %0d cfg %h", job_ready_o, queue_cnt_o, cfg_o[0]); end
        tick(); tick();
        checks++; if (busy_o !== 2'b01 || queue_cnt_o !== 3'd3) begin errors++; $display("FAIL q_block busy %b cnt %0d exp 01 3", busy_o, queue_cnt_o); end
        src_done_i[0] = 1'b1; snk_done_i[0] = 1'b1;
        tick();
        checks++; if (done_evt_o !== 2'b01) begin errors++; $display("FAIL q_done1 got %b exp 01", done_evt_o); end
        src_done_i = '0; snk_done_i = '0;
        tick(); tick();
        checks++; if (cfg_o[0] !== mk_cfg(32'h2200) || queue_cnt_o !== 3'd2) begin errors++; $display("FAIL q_j2 cnt %0d cfg %h", queue_cnt_o, cfg_o[0]); end
        tick();
        checks++; if (busy_o !== 2'b11 || snk_req_start_o !== 2'b10 || queue_cnt_o !== 3'd1 || cfg_o[1] !== mk_cfg(32'h2300)) begin errors++; $display("FAIL q_j3 busy %b req %b cnt %0d", busy_o, snk_req_start_o, queue_cnt_o); end
        tick();
        src_done_i[0] = 1'b1; snk_done_i[0] = 1'b1;
        tick();
        checks++; if (done_evt_o !== 2'b01) begin errors++; $display("FAIL q_done2 got %b exp 01", done_evt_o); end
        src_done_i = '0; snk_done_i = '0;
        tick();
        src_done_i[1] = 1'b1; snk_done_i[1] = 1'b1;
        tick();
        checks++; if (done_evt_o !== 2'b10) begin errors++; $display("FAIL q_done3 got %b exp 10", done_evt_o); end
        src_done_i = '0; snk_done_i = '0;
        tick(); tick();
        checks++; if (cfg_o[1] !== mk_cfg(32'h2400) || queue_cnt_o !== 3'd0 || src_req_start_o !== 2'b10) begin errors++; $display("FAIL q_j4 cnt %0d req %b", queue_cnt_o, src_req_start_o); end
        tick();
        src_done_i[1] = 1'b1; snk_done_i[1] = 1'b1;
        tick();
        checks++; if (done_evt_o !== 2'b10) begin errors++; $display("FAIL q_done4 got %b exp 10", done_evt_o); end
        src_done_i = '0; snk_done_i = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        push(1'b0, mk_cfg(32'h3000));
        push(1'b1, mk_cfg(32'h3100));
        tick(); tick();
        checks++; if (busy_o !== 2'b11 || done_evt_o !== 2'b00) begin errors++; $display("FAIL sim_work busy %b done %b exp 11 00", busy_o, done_evt_o); end
        src_ready_start_i = 2'b11; snk_done_i = 2'b11;
        tick();
        checks++; if (done_evt_o !== 2'b11) begin errors++; $display("FAIL sim_done got %b exp 11", done_evt_o); end
        src_ready_start_i = '0; snk_done_i = '0;
        tick();
        checks++; if (busy_o !== 2'b00 || done_evt_o !== 2'b00) begin errors++; $display("FAIL sim_idle busy %b done %b exp 00 00", busy_o, done_evt_o); end
    endtask

    task automatic test_abort();
        push(1'b1, mk_cfg(32'h4000));
        tick(); tick();
        abort_i[1] = 1'b1;
        tick();
        checks++; if (done_evt_o !== 2'b10 || aborted_o !== 2'b10 || cycles_o[1] !== 32'd2) begin errors++; $display("FAIL ab_fin done %b ab %b cyc %0d exp 10 10 2", done_evt_o, aborted_o, cycles_o[1]); end
        abort_i = '0;
        tick();
        abort_i = 2'b11;
        tick();
        checks++; if (aborted_o !== 2'b10 || busy_o !== 2'b00) begin errors++; $display("FAIL ab_idle ab %b busy %b exp 10 00", aborted_o, busy_o); end
        abort_i = '0;
        push(1'b1, mk_cfg(32'h4100));
        tick();
        checks++; if (aborted_o !== 2'b00 || cycles_o[1] !== 32'd0 || busy_o !== 2'b10) begin errors++; $display("FAIL ab_clr ab %b cyc %0d busy %b exp 00 0 10", aborted_o, cycles_o[1], busy_o); end
        abort_i[1] = 1'b1;
        tick();
        checks++; if (done_evt_o !== 2'b10 || aborted_o !== 2'b10 || cycles_o[1] !== 32'd1) begin errors++; $display("FAIL ab_start done %b ab %b cyc %0d exp 10 10 1", done_evt_o, aborted_o, cycles_o[1]); end
        abort_i = '0;
        tick();
    endtask

    task automatic test_clear();
        push(1'b0, mk_cfg(32'h5000));
        tick(); tick();
        push(1'b0, mk_cfg(32'h5100));
        push(1'b0, mk_cfg(32'h5200));
        checks++; if (queue_cnt_o !== 3'd2 || busy_o !== 2'b01) begin errors++; $display("FAIL clr_pre cnt %0d busy %b exp 2 01", queue_cnt_o, busy_o); end
        clear_i = 1'b1; job_valid_i = 1'b1; job_chan_i = 1'b1; job_cfg_i = mk_cfg(32'h5300);
        tick();
        checks++; if (busy_o !== 2'b00 || queue_cnt_o !== 3'd0 || done_evt_o !== 2'b00 || src_req_start_o !== 2'b00) begin errors++; $display("FAIL clr_now busy %b cnt %0d done %b req %b", busy_o, queue_cnt_o, done_evt_o, src_req_start_o); end
        checks++; if (cycles_o[0] !== 32'd0 || cfg_o[0] !== '0 || job_ready_o !== 1'b0) begin errors++; $display("FAIL clr_regs cyc %0d ready %b", cycles_o[0], job_ready_o); end
        clear_i = 1'b0; job_valid_i = 1'b0;
        tick();
        checks++; if (busy_o !== 2'b00 || done_evt_o !== 2'b00 || queue_cnt_o !== 3'd0 || job_ready_o !== 1'b1) begin errors++; $display("FAIL clr_after busy %b done %b cnt %0d ready %b", busy_o, done_evt_o, queue_cnt_o, job_ready_o); end
        tick();
        checks++; if (busy_o !== 2'b00 || src_req_start_o !== 2'b00) begin errors++; $display("FAIL clr_nodisp busy %b req %b exp 00 00", busy_o, src_req_start_o); end
    endtask

    task automatic test_saturate();
        push(1'b0, mk_cfg(32'h6000));
        tick(); tick();
        repeat (19) tick();
        checks++; if (s_cycles_o[0] !== 4'd15 || s_busy_o !== 2'b01) begin errors++; $display("FAIL sat_hold cyc %0d busy %b exp 15 01", s_cycles_o[0], s_busy_o); end
        checks++; if (cycles_o[0] !== 32'd20) begin errors++; $display("FAIL sat_wide cyc %0d exp 20", cycles_o[0]); end
        src_done_i[0] = 1'b1; snk_done_i[0] = 1'b1;
        tick();
        checks++; if (s_cycles_o[0] !== 4'd15 || s_done_evt_o !== 2'b01 || cycles_o[0] !== 32'd21) begin errors++; $display("FAIL sat_fin cyc %0d done %b wide %0d exp 15 01 21", s_cycles_o[0], s_done_evt_o, cycles_o[0]); end
        src_done_i = '0; snk_done_i = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue_order();
        test_simultaneous();
        test_abort();
        test_clear();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
